taillight_sequencer_ctrl: RTL

- Controller that sequences the six tail lamps (three left, three right) from driver requests: left turn, right turn, hazard and brake.
- Holds each pattern step for TICK_DIV clocks, arbitrates between concurrent requests and drives the lamp outputs directly.
- Sits between the switch-debounce logic and the lamp drivers; it is the only block that decides which lamp pattern is shown.

---
 rtl/taillight_pkg.sv | 54 +++++
 rtl/taillight_step_timer.sv | 46 ++++
 rtl/taillight_sequencer_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/taillight_pkg.sv
// -----------------------------------------------------------------------------
// taillight_pkg
// Shared definitions for the tail-lamp sequencer:
//   - state_t          : controller state encoding (4 bits)
//   - LAMPS_*          : 6-bit lamp patterns, bit order
//                        {left_c, left_b, left_a, right_a, right_b, right_c}
//   - DEFAULT_TICK_DIV : default number of clocks each pattern step is held
//   - lamp_pattern()   : state -> lamp pattern decode
// -----------------------------------------------------------------------------
package taillight_pkg;

    localparam int DEFAULT_TICK_DIV = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_L1     = 4'd1,
        ST_L2     = 4'd2,
        ST_L3     = 4'd3,
        ST_R1     = 4'd4,
        ST_R2     = 4'd5,
        ST_R3     = 4'd6,
        ST_HAZ_ON = 4'd7,
        ST_GAP    = 4'd8
    } state_t;

    // Left lamps light outward from a, right lamps light outward from a.
    localparam logic [5:0] LAMPS_OFF   = 6'b000_000;
    localparam logic [5:0] LAMPS_L1    = 6'b001_000;
    localparam logic [5:0] LAMPS_L2    = 6'b011_000;
    localparam logic [5:0] LAMPS_L3    = 6'b111_000;
    localparam logic [5:0] LAMPS_R1    = 6'b000_100;
    localparam logic [5:0] LAMPS_R2    = 6'b000_110;
    localparam logic [5:0] LAMPS_R3    = 6'b000_111;
    localparam logic [5:0] LAMPS_LEFT  = 6'b111_000;
    localparam logic [5:0] LAMPS_RIGHT = 6'b000_111;
    localparam logic [5:0] LAMPS_ALL   = 6'b111_111;

    function automatic logic [5:0] lamp_pattern(input state_t s);
        logic [5:0] p;
        p = LAMPS_OFF;
        case (s)
            ST_L1:     p = LAMPS_L1;
            ST_L2:     p = LAMPS_L2;
            ST_L3:     p = LAMPS_L3;
            ST_R1:     p = LAMPS_R1;
            ST_R2:     p = LAMPS_R2;
            ST_R3:     p = LAMPS_R3;
            ST_HAZ_ON: p = LAMPS_ALL;
            default:   p = LAMPS_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/taillight_step_timer.sv
// -----------------------------------------------------------------------------
// taillight_step_timer
// Step counter that measures how long the sequencer has been in its current
// state. step_done marks the last cycle of a TICK_DIV-cycle step.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   clear     in   state is changing on this edge; restart the count at 0
//   run       in   count this cycle (controller is not idle)
//   step_done out  counter == TICK_DIV-1
// Parameters: TICK_DIV (2..65535), CNT_W with 2**CNT_W > TICK_DIV.
// -----------------------------------------------------------------------------
module taillight_step_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic step_done
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (run) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign step_done = (count_reg == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/taillight_sequencer_ctrl.sv
// -----------------------------------------------------------------------------
// taillight_sequencer_ctrl
// Sequences six tail lamps from left/right/hazard/brake requests. Each pattern
// step is held for TICK_DIV clocks; the lamps are Moore decodes of the state
// register (plus brake overlay when enabled), so they change on the same edge
// as the state.
// Ports:
//   clk, reset                     clock / synchronous active-high reset
//   left, right, hazard, brake     level requests from debounce logic
//   left_a/b/c, right_a/b/c        lamp drives, a = innermost, c = outermost
//   busy                           high whenever the state is not IDLE
// Optional build macro:
//   TAILLIGHT_BRAKE_EN  brake lights dark lamps: all six in IDLE/GAP, the
//                       opposite side during a turn. Never affects state.
//                       When undefined, brake is accepted but ignored.
// -----------------------------------------------------------------------------
module taillight_sequencer_ctrl
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic left_a,
    output logic left_b,
    output logic left_c,
    output logic right_a,
    output logic right_b,
    output logic right_c,
    output logic busy
);

    state_t     state_reg;
    state_t     state_next;
    logic       step_done;
    logic       state_change;
    logic [5:0] lamp_vec;

    // Restart the step count on every state change so each non-idle state
    // lasts exactly TICK_DIV cycles.
    assign state_change = (state_next != state_reg);

    taillight_step_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_step_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_change),
        .run       (state_reg != ST_IDLE),
        .step_done (step_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // First match wins; left and right together is ignored.
                if (hazard) begin
                    state_next = ST_HAZ_ON;
                end else if (left && !right) begin
                    state_next = ST_L1;
                end else if (right && !left) begin
                    state_next = ST_R1;
                end
            end
            // A hazard request pre-empts a turn at the next step boundary.
            ST_L1: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_L2;
            ST_L2: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_L3;
            ST_L3: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_GAP;
            ST_R1: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_R2;
            ST_R2: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_R3;
            ST_R3: if (step_done) state_next = hazard ? ST_HAZ_ON : ST_GAP;
            ST_HAZ_ON: if (step_done) state_next = ST_GAP;
            ST_GAP:    if (step_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef TAILLIGHT_BRAKE_EN
    always_comb begin
        lamp_vec = lamp_pattern(state_reg);
        if (brake) begin
            case (state_reg)
                ST_IDLE, ST_GAP:      lamp_vec = LAMPS_ALL;
                ST_L1, ST_L2, ST_L3:  lamp_vec = lamp_pattern(state_reg) | LAMPS_RIGHT;
                ST_R1, ST_R2, ST_R3:  lamp_vec = lamp_pattern(state_reg) | LAMPS_LEFT;
                default:              lamp_vec = lamp_pattern(state_reg);
            endcase
        end
    end
`else
    // Brake is part of the fixed port list but has no function in this build.
    logic unused_brake;
    assign unused_brake = brake;
    assign lamp_vec     = lamp_pattern(state_reg);
`endif

    assign {left_c, left_b, left_a, right_a, right_b, right_c} = lamp_vec;
    assign busy = (state_reg != ST_IDLE);

endmodule
